// File: rtl/roc_dp.sv
// Self-clearing single-clock RAM with registered read port, range checking and a zeroing sequence after reset.
// Define ROC_DP_BYPASS_EN for write-first same-address read-during-write; the default build is read-first.
module roc_dp #(
    parameter int DW  = 8,
    parameter int AW  = 4,
    parameter int DEP = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] data,
    input  logic          rd,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          busy,
    output logic          err
);

    typedef enum logic {CLEAR, READY} state_t;

`ifdef ROC_DP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // One extra bit so the range check also works when DEP == 2**AW.
    localparam logic [AW:0]   DEP_L = (AW+1)'(DEP);
    localparam logic [AW-1:0] LAST  = AW'(DEP - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;

    logic [DW-1:0] mem_q [DEP];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic wr_in_range, rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DEP_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEP_L);

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr_q;
        mem_wdata  = '0;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr_q == LAST) begin
                    state_d   = READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                if (wr && wr_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr;
                    mem_wdata = data;
                end
                if (rd && rd_in_range) begin
                    rd_valid_d = 1'b1;
                    if (BYPASS && wr && wr_in_range && (wr_addr == rd_addr))
                        data_out_d = data;
                    else
                        data_out_d = mem_q[rd_addr];
                end
                err_d = (wr && !wr_in_range) || (rd && !rd_in_range);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage has no reset; the clear sequence is what zeroes it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_roc_dp.sv
// Directed bench for roc_dp: one DEP=16 instance and one DEP=12 instance for range checks.
module tb_roc_dp;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DEP=16 instance
    logic       a_rst, a_wr, a_rd, a_valid, a_busy, a_err;
    logic [3:0] a_waddr, a_raddr;
    logic [7:0] a_data, a_dout;
    // DEP=12 instance
    logic       b_rst, b_wr, b_rd, b_valid, b_busy, b_err;
    logic [3:0] b_waddr, b_raddr;
    logic [7:0] b_data, b_dout;

    roc_dp #(.DW(8), .AW(4), .DEP(16)) u_dut (
        .clk(clk), .rst(a_rst), .wr(a_wr), .wr_addr(a_waddr), .data(a_data),
        .rd(a_rd), .rd_addr(a_raddr), .data_out(a_dout), .rd_valid(a_valid),
        .busy(a_busy), .err(a_err)
    );

    roc_dp #(.DW(8), .AW(4), .DEP(12)) u_dut12 (
        .clk(clk), .rst(b_rst), .wr(b_wr), .wr_addr(b_waddr), .data(b_data),
        .rd(b_rd), .rd_addr(b_raddr), .data_out(b_dout), .rd_valid(b_valid),
        .busy(b_busy), .err(b_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_wr = 1'b0; a_rd = 1'b0; a_waddr = '0; a_raddr = '0; a_data = '0;
    endtask

    task automatic b_idle();
        b_wr = 1'b0; b_rd = 1'b0; b_waddr = '0; b_raddr = '0; b_data = '0;
    endtask

    localparam logic [7:0] SAME_EXP =
`ifdef ROC_DP_BYPASS_EN
        8'h55;
`else
        8'hAA;
`endif

    initial begin
        int cnt;
        bit saw_valid, saw_err;
        a_rst = 1'b1; b_rst = 1'b1;
        a_idle(); b_idle();
        @(negedge clk);

        // ---------------- DEP=16 ----------------
        tick();
        chk("rst_busy", 32'(a_busy), 1);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_dout", 32'(a_dout), 0);
        a_rst = 1'b0;

        // Clear sequence with requests thrown at it; a write to addr 2 at cycle 5
        // lands after the pointer passed 2, so it would stick if not ignored.
        cnt = 0; saw_valid = 0; saw_err = 0;
        while (a_busy && cnt < 40) begin
            a_rd = 1'b1; a_raddr = 4'(cnt);
            a_wr = (cnt == 5); a_waddr = 4'd2; a_data = 8'h77;
            cnt++;
            tick();
            if (a_valid) saw_valid = 1;
            if (a_err) saw_err = 1;
        end
        a_idle();
        chk("clr_len", 32'(cnt), 16);
        chk("clr_no_valid", 32'(saw_valid), 0);
        chk("clr_no_err", 32'(saw_err), 0);

        for (int i = 0; i < 16; i++) begin
            a_rd = 1'b1; a_raddr = 4'(i);
            tick();
            chk($sformatf("zero_d%0d", i), 32'(a_dout), 0);
            chk($sformatf("zero_v%0d", i), 32'(a_valid), 1);
        end
        a_idle();
        tick();
        chk("idle_valid", 32'(a_valid), 0);

        // write then read back
        a_wr = 1'b1; a_waddr = 4'd8; a_data = 8'h51;
        tick();
        chk("wr_no_valid", 32'(a_valid), 0);
        a_idle(); a_rd = 1'b1; a_raddr = 4'd8;
        tick();
        chk("rd8_dout", 32'(a_dout), 32'h51);
        chk("rd8_valid", 32'(a_valid), 1);
        a_idle();
        tick();
        chk("hold_valid", 32'(a_valid), 0);
        chk("hold_dout", 32'(a_dout), 32'h51);

        // same-address read during write
        a_wr = 1'b1; a_waddr = 4'd3; a_data = 8'hAA;
        tick();
        a_wr = 1'b1; a_waddr = 4'd3; a_data = 8'h55; a_rd = 1'b1; a_raddr = 4'd3;
        tick();
        chk("rdw_dout", 32'(a_dout), 32'(SAME_EXP));
        chk("rdw_valid", 32'(a_valid), 1);
        a_idle(); a_rd = 1'b1; a_raddr = 4'd3;
        tick();
        chk("rdw_mem", 32'(a_dout), 32'h55);

        // different-address write and read in one cycle
        a_idle();
        a_wr = 1'b1; a_waddr = 4'd5; a_data = 8'hC3; a_rd = 1'b1; a_raddr = 4'd8;
        tick();
        chk("dual_rd", 32'(a_dout), 32'h51);
        a_idle(); a_rd = 1'b1; a_raddr = 4'd5;
        tick();
        chk("dual_wr", 32'(a_dout), 32'hC3);

        // second clear, interrupted by reset at clear cycle 7
        a_idle(); a_rst = 1'b1;
        tick();
        chk("rst2_dout", 32'(a_dout), 0);
        chk("rst2_busy", 32'(a_busy), 1);
        a_rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_busy", 32'(a_busy), 1);
        a_rst = 1'b1; a_rd = 1'b1; a_raddr = 4'd5;
        tick();
        chk("mid_rst_valid", 32'(a_valid), 0);
        a_rst = 1'b0; a_idle();
        cnt = 0;
        while (a_busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("clr2_len", 32'(cnt), 16);
        a_rd = 1'b1; a_raddr = 4'd5;
        tick();
        chk("clr2_zero", 32'(a_dout), 0);
        a_idle();

        // ---------------- DEP=12 ----------------
        tick();
        b_rst = 1'b0;
        cnt = 0;
        while (b_busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("b_clr_len", 32'(cnt), 12);
        for (int i = 0; i < 12; i++) begin
            b_wr = 1'b1; b_waddr = 4'(i); b_data = 8'(8'h10 + i);
            tick();
        end
        b_idle(); b_wr = 1'b1; b_waddr = 4'd13; b_data = 8'hFF;
        tick();
        chk("b_wr_oor_err", 32'(b_err), 1);
        b_idle();
        tick();
        chk("b_err_clear", 32'(b_err), 0);
        for (int i = 0; i < 12; i++) begin
            b_rd = 1'b1; b_raddr = 4'(i);
            tick();
            chk($sformatf("b_rd%0d", i), 32'(b_dout), 32'(8'h10 + i));
        end
        b_idle(); b_rd = 1'b1; b_raddr = 4'd14;
        tick();
        chk("b_rd_oor_err", 32'(b_err), 1);
        chk("b_rd_oor_valid", 32'(b_valid), 0);
        chk("b_rd_oor_hold", 32'(b_dout), 32'h1B);
        // out-of-range read alongside an in-range write
        b_idle(); b_wr = 1'b1; b_waddr = 4'd4; b_data = 8'h9E; b_rd = 1'b1; b_raddr = 4'd12;
        tick();
        chk("b_mix_err", 32'(b_err), 1);
        b_idle(); b_rd = 1'b1; b_raddr = 4'd4;
        tick();
        chk("b_mix_wr", 32'(b_dout), 32'h9E);
        chk("b_mix_noerr", 32'(b_err), 0);
        b_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
